parity_rx: RTL

PARITY_RX -- requirements
Module: parity_rx

---
 rtl/parity_rx_pkg.sv | 5 +
 rtl/parity_rx_if.sv | 18 +
 rtl/parity_rx_par_acc.sv | 15 +
 rtl/parity_rx.sv | 69 ++++++
 4 files changed

// File: rtl/parity_rx_pkg.sv
// parity_rx_pkg: shared FSM state encoding and default payload width for the parity receiver.
package parity_rx_pkg;
  localparam int DATA_W_DEF = 8;
  typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1, PARITY = 2'd2, STOP = 2'd3} state_t;
endpackage

// File: rtl/parity_rx_if.sv
// parity_rx_if: serial input, output word handshake and status flags of the receiver.
interface parity_rx_if
  import parity_rx_pkg::*;
#(parameter int DATA_W = DATA_W_DEF) ();
  logic              bit_en;
  logic              sdin;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic              dout_ready;
  logic              parity_err;
  logic              frame_err;
  logic              overrun;
  logic              busy;
  modport master (output bit_en, sdin, dout_ready,
                  input dout, dout_valid, parity_err, frame_err, overrun, busy);
  modport slave (input bit_en, sdin, dout_ready,
                 output dout, dout_valid, parity_err, frame_err, overrun, busy);
endinterface

// File: rtl/parity_rx_par_acc.sv
// par_acc: serial XOR accumulator with synchronous clear and enable.
module par_acc (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  input  logic i_d,
  output logic o_acc
);
  logic r_acc;
  always_ff @(posedge clk)
    if (!rst_n || i_clr) r_acc <= 1'b0;
    else if (i_en) r_acc <= r_acc ^ i_d;
  assign o_acc = r_acc;
endmodule

// File: rtl/parity_rx.sv
// parity_rx: start/data/parity/stop frame receiver gated by bit_en,
// delivering each word through a one-deep valid/ready holding register.
module parity_rx
  import parity_rx_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter bit ODD    = 1'b0
) (
  input logic        clk,
  input logic        rst_n,
  parity_rx_if.slave bus
);
  localparam int CW = $clog2(DATA_W);
  state_t            r_state;
  logic [CW-1:0]     r_cnt;
  logic [DATA_W-1:0] r_shift, r_dout;
  logic              r_err, r_valid, r_perr, r_ferr, r_ovr;
  logic              w_acc, w_clr, w_en;
  assign w_clr = bus.bit_en && r_state == IDLE && !bus.sdin;
  assign w_en  = bus.bit_en && r_state == DATA;
  par_acc u_acc (.clk, .rst_n, .i_clr(w_clr), .i_en(w_en), .i_d(bus.sdin), .o_acc(w_acc));
  always_ff @(posedge clk)
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_shift <= '0;
      r_err   <= 1'b0;
      r_dout  <= '0;
      r_valid <= 1'b0;
      r_perr  <= 1'b0;
      r_ferr  <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_ovr <= 1'b0;
      if (r_valid && bus.dout_ready) r_valid <= 1'b0;
      if (bus.bit_en)
        unique case (r_state)
          IDLE: if (!bus.sdin) begin
            r_state <= DATA;
            r_cnt   <= '0;
          end
          DATA: begin
            r_shift[r_cnt] <= bus.sdin;
            r_cnt          <= r_cnt + 1'b1;
            if (r_cnt == CW'(DATA_W - 1)) r_state <= PARITY;
          end
          PARITY: begin
            r_err   <= w_acc ^ bus.sdin ^ ODD;
            r_state <= STOP;
          end
          STOP: begin
            r_state <= IDLE;
            // a word still held and not being taken this edge wins; the new one is dropped
            if (!r_valid || bus.dout_ready) begin
              r_dout  <= r_shift;
              r_perr  <= r_err;
              r_ferr  <= !bus.sdin;
              r_valid <= 1'b1;
            end else r_ovr <= 1'b1;
          end
        endcase
    end
  assign bus.dout       = r_dout;
  assign bus.dout_valid = r_valid;
  assign bus.parity_err = r_perr;
  assign bus.frame_err  = r_ferr;
  assign bus.overrun    = r_ovr;
  assign bus.busy       = r_state != IDLE;
endmodule
